// File: rtl/button_event_ctrl_pkg.sv
// Shared definitions for the button event controller: event codes,
// per-button FSM state encoding and width helpers.
package button_event_ctrl_pkg;

  // Event type codes carried on oEvtType.
  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_LONG    = 2'b01,
    EVT_REPEAT  = 2'b10,
    EVT_RELEASE = 2'b11
  } evtType_t;

  // Per-button FSM states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEB_PRESS = 3'd1,
    ST_PRESSED   = 3'd2,
    ST_HELD      = 3'd3,
    ST_DEB_REL   = 3'd4
  } btnState_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Width of a counter that must hold 0..maxVal, never below 1 bit.
  function automatic int cntWidth(input int maxVal);
    return (clog2(maxVal + 1) < 1) ? 1 : clog2(maxVal + 1);
  endfunction

  // Width of the button index bus: max(1, clog2(n)).
  function automatic int idWidth(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/button_event_fsm.sv
// One button: debounce/hold FSM with millisecond timers plus a single-entry
// pending event slot that the arbiter drains.
module button_event_fsm
  import button_event_ctrl_pkg::*;
#(
  parameter int P_DEBOUNCE_MS = 20,
  parameter int P_LONG_MS     = 1000,
  parameter int P_REPEAT_MS   = 200
) (
  input  logic       iClk,
  input  logic       iRstn,
  input  logic       iTick,
  input  logic       iLevel,
  input  logic       iGrant,
  output logic       oPendValid,
  output logic [1:0] oPendType,
  output logic       oDrop
);

  localparam int TW = cntWidth((P_LONG_MS > P_REPEAT_MS) ? P_LONG_MS : P_REPEAT_MS);
  localparam int DW = cntWidth(P_DEBOUNCE_MS);
  localparam logic [DW-1:0] DEB_LAST    = DW'(P_DEBOUNCE_MS - 1);
  localparam logic [TW-1:0] LONG_LAST   = TW'(P_LONG_MS - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(P_REPEAT_MS - 1);

  btnState_t     state, stateNext;
  logic [TW-1:0] timer, timerNext;     // hold timer, frozen while debouncing a release
  logic [DW-1:0] debCnt, debCntNext;   // debounce tick counter for both edges
  logic          retHeld, retHeldNext; // DEB_REL resumes into HELD when set
  logic          emit;
  evtType_t      emitType;

  // FSM state, timers and return flag registers.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state   <= ST_IDLE;
      timer   <= '0;
      debCnt  <= '0;
      retHeld <= 1'b0;
    end else begin
      state   <= stateNext;
      timer   <= timerNext;
      debCnt  <= debCntNext;
      retHeld <= retHeldNext;
    end
  end

  // Next-state, timer updates and event emission.
  always_comb begin
    stateNext   = state;
    timerNext   = timer;
    debCntNext  = debCnt;
    retHeldNext = retHeld;
    emit        = 1'b0;
    emitType    = EVT_PRESS;
    case (state)
      ST_IDLE: begin
        if (iLevel) begin
          stateNext  = ST_DEB_PRESS;
          debCntNext = '0;
          timerNext  = '0;
        end else begin
          stateNext = ST_IDLE;
        end
      end
      ST_DEB_PRESS: begin
        if (!iLevel) begin
          stateNext = ST_IDLE;
        end else if (iTick) begin
          if (debCnt == DEB_LAST) begin
            stateNext = ST_PRESSED;
            timerNext = '0;
            emit      = 1'b1;
            emitType  = EVT_PRESS;
          end else begin
            debCntNext = debCnt + DW'(1);
          end
        end else begin
          stateNext = ST_DEB_PRESS;
        end
      end
      ST_PRESSED: begin
        if (!iLevel) begin
          stateNext   = ST_DEB_REL;
          debCntNext  = '0;
          retHeldNext = 1'b0;
        end else if (iTick) begin
          if (timer == LONG_LAST) begin
            stateNext = ST_HELD;
            timerNext = '0;
            emit      = 1'b1;
            emitType  = EVT_LONG;
          end else begin
            timerNext = timer + TW'(1);
          end
        end else begin
          stateNext = ST_PRESSED;
        end
      end
      ST_HELD: begin
        if (!iLevel) begin
          stateNext   = ST_DEB_REL;
          debCntNext  = '0;
          retHeldNext = 1'b1;
        end else if (iTick) begin
          if (timer == REPEAT_LAST) begin
            timerNext = '0;
            emit      = 1'b1;
            emitType  = EVT_REPEAT;
          end else begin
            timerNext = timer + TW'(1);
          end
        end else begin
          stateNext = ST_HELD;
        end
      end
      ST_DEB_REL: begin
        // A bounce back to 1 resumes the hold phase with its timer intact.
        if (iLevel) begin
          stateNext = retHeld ? ST_HELD : ST_PRESSED;
        end else if (iTick) begin
          if (debCnt == DEB_LAST) begin
            stateNext = ST_IDLE;
            emit      = 1'b1;
            emitType  = EVT_RELEASE;
          end else begin
            debCntNext = debCnt + DW'(1);
          end
        end else begin
          stateNext = ST_DEB_REL;
        end
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // Pending slot: a new emit always wins; a grant alone empties the slot.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      oPendValid <= 1'b0;
      oPendType  <= 2'b00;
    end else if (emit) begin
      oPendValid <= 1'b1;
      oPendType  <= emitType;
    end else if (iGrant) begin
      oPendValid <= 1'b0;
    end else begin
      oPendValid <= oPendValid;
    end
  end

  // Overwrite of an event that is not leaving this cycle is a drop.
  assign oDrop = emit & oPendValid & ~iGrant;

endmodule

// File: rtl/button_event_ctrl.sv
// Debounced button event controller: shared 1 ms tick, one FSM per button,
// round-robin arbitration onto a registered valid/ready event channel.
module button_event_ctrl
  import button_event_ctrl_pkg::*;
#(
  parameter int P_BUTTON_WIDTH = 5,
  parameter int P_TICK_DIV     = 100000,
  parameter int P_DEBOUNCE_MS  = 20,
  parameter int P_LONG_MS      = 1000,
  parameter int P_REPEAT_MS    = 200
) (
  input  logic                              iClk,
  input  logic                              iRstn,
  input  logic [P_BUTTON_WIDTH-1:0]         iButtonLevel,
  output logic                              oEvtValid,
  input  logic                              iEvtReady,
  output logic [idWidth(P_BUTTON_WIDTH)-1:0] oEvtId,
  output logic [1:0]                        oEvtType,
  output logic                              oEvtDrop
);

  localparam int IDW   = idWidth(P_BUTTON_WIDTH);
  localparam int TICKW = cntWidth(P_TICK_DIV - 1);

  logic [TICKW-1:0]          tickCnt;
  logic                      wTick;
  logic [P_BUTTON_WIDTH-1:0] pendValid;
  logic [1:0]                pendType [P_BUTTON_WIDTH];
  logic [P_BUTTON_WIDTH-1:0] dropVec;
  logic [P_BUTTON_WIDTH-1:0] grantVec;
  logic [IDW-1:0]            rPtr;
  logic                      load;
  logic                      found;
  logic [IDW-1:0]            pick;

  assign wTick = (tickCnt == TICKW'(P_TICK_DIV - 1));

  // Millisecond tick counter, wrapping at P_TICK_DIV-1.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      tickCnt <= '0;
    end else if (wTick) begin
      tickCnt <= '0;
    end else begin
      tickCnt <= tickCnt + TICKW'(1);
    end
  end

  for (genvar g = 0; g < P_BUTTON_WIDTH; g++) begin : gBtn
    button_event_fsm #(
      .P_DEBOUNCE_MS (P_DEBOUNCE_MS),
      .P_LONG_MS     (P_LONG_MS),
      .P_REPEAT_MS   (P_REPEAT_MS)
    ) uFsm (
      .iClk       (iClk),
      .iRstn      (iRstn),
      .iTick      (wTick),
      .iLevel     (iButtonLevel[g]),
      .iGrant     (grantVec[g]),
      .oPendValid (pendValid[g]),
      .oPendType  (pendType[g]),
      .oDrop      (dropVec[g])
    );
  end

  // The output register may take a new event when empty or being accepted.
  assign load = !oEvtValid || iEvtReady;

  // Round-robin search for the first pending slot at or after rPtr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < P_BUTTON_WIDTH; k++) begin
      if (!found && pendValid[(int'(rPtr) + k) % P_BUTTON_WIDTH]) begin
        found = 1'b1;
        pick  = IDW'((int'(rPtr) + k) % P_BUTTON_WIDTH);
      end else begin
        found = found;
      end
    end
  end

  // One-hot grant back to the slot being moved into the output register.
  always_comb begin
    grantVec = '0;
    if (load && found) begin
      grantVec[pick] = 1'b1;
    end else begin
      grantVec = '0;
    end
  end

  // Output register, round-robin pointer and registered drop pulse.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      oEvtValid <= 1'b0;
      oEvtId    <= '0;
      oEvtType  <= 2'b00;
      oEvtDrop  <= 1'b0;
      rPtr      <= '0;
    end else begin
      oEvtDrop <= |dropVec;
      if (load) begin
        if (found) begin
          oEvtValid <= 1'b1;
          oEvtId    <= pick;
          oEvtType  <= pendType[pick];
          rPtr      <= (pick == IDW'(P_BUTTON_WIDTH - 1)) ? '0 : pick + IDW'(1);
        end else begin
          oEvtValid <= 1'b0;
        end
      end else begin
        oEvtValid <= oEvtValid;
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with a fast tick (4 cycles per ms).
module tb_button_event_ctrl;

  logic       iClk = 1'b0;
  logic       iRstn;
  logic [4:0] iButtonLevel;
  logic       iEvtReady;
  logic       oEvtValid;
  logic [2:0] oEvtId;
  logic [1:0] oEvtType;
  logic       oEvtDrop;

  int nVec  = 0;
  int nMiss = 0;
  int cyc   = 0;
  int dropCnt = 0;
  int logId[$];
  int logType[$];
  int logCyc[$];

  always #5 iClk = ~iClk;

  button_event_ctrl #(
    .P_BUTTON_WIDTH (5),
    .P_TICK_DIV     (4),
    .P_DEBOUNCE_MS  (3),
    .P_LONG_MS      (10),
    .P_REPEAT_MS    (4)
  ) dut (
    .iClk         (iClk),
    .iRstn        (iRstn),
    .iButtonLevel (iButtonLevel),
    .oEvtValid    (oEvtValid),
    .iEvtReady    (iEvtReady),
    .oEvtId       (oEvtId),
    .oEvtType     (oEvtType),
    .oEvtDrop     (oEvtDrop)
  );

  // Accepted-event log and drop counter, sampled on the falling edge.
  always @(negedge iClk) begin
    cyc <= cyc + 1;
    if (oEvtValid === 1'b1 && iEvtReady === 1'b1) begin
      logId.push_back(int'(oEvtId));
      logType.push_back(int'(oEvtType));
      logCyc.push_back(cyc + 1);
    end
    if (oEvtDrop === 1'b1) begin
      dropCnt <= dropCnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMiss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic waitLog(input int need, input int budget, input string tag);
    int i;
    i = 0;
    while (logId.size() < need && i < budget) begin
      @(posedge iClk);
      #1;
      i++;
    end
    check(tag, 32'(logId.size() >= need), 32'd1);
  endtask

  task automatic waitValid(input int budget, input string tag);
    int i;
    i = 0;
    while (oEvtValid !== 1'b1 && i < budget) begin
      @(posedge iClk);
      #1;
      i++;
    end
    check(tag, 32'(oEvtValid), 32'd1);
  endtask

  initial begin
    int b;
    int b2;
    int c0;
    int d0;
    int lat;
    logic stable;
    int expT [7];
    expT = '{0, 1, 2, 2, 2, 2, 3};

    iRstn        = 1'b0;
    iButtonLevel = 5'b00000;
    iEvtReady    = 1'b1;
    #12;
    check("rst_valid", 32'(oEvtValid), 32'd0);
    check("rst_id",    32'(oEvtId),    32'd0);
    check("rst_type",  32'(oEvtType),  32'd0);
    check("rst_drop",  32'(oEvtDrop),  32'd0);
    @(posedge iClk);
    #1;
    iRstn = 1'b1;
    cycles(3);

    // 1. Bounce on btn2, then steady press and release.
    b = logId.size();
    for (int r = 0; r < 12; r++) begin
      iButtonLevel[2] = (r % 2 == 0);
      cycles(5);
    end
    check("t1_no_bounce_evt", 32'(logId.size()), 32'(b));
    iButtonLevel[2] = 1'b1;
    c0 = cyc;
    waitLog(b + 1, 20, "t1_press_timeout");
    if (logId.size() >= b + 1) begin
      check("t1_press_id",   32'(logId[b]),   32'd2);
      check("t1_press_type", 32'(logType[b]), 32'd0);
      lat = logCyc[b] - c0;
      check("t1_press_lat_in_12_15", 32'(lat >= 12 && lat <= 15), 32'd1);
    end
    cycles(20);
    check("t1_single_press", 32'(logId.size()), 32'(b + 1));
    iButtonLevel[2] = 1'b0;
    c0 = cyc;
    waitLog(b + 2, 20, "t1_release_timeout");
    if (logId.size() >= b + 2) begin
      check("t1_rel_id",   32'(logId[b + 1]),   32'd2);
      check("t1_rel_type", 32'(logType[b + 1]), 32'd3);
      lat = logCyc[b + 1] - c0;
      check("t1_rel_lat_in_12_15", 32'(lat >= 12 && lat <= 15), 32'd1);
    end

    // 2. Hold btn0 for ~30 ticks: PRESS, LONG, 4x REPEAT, RELEASE.
    b = logId.size();
    iButtonLevel[0] = 1'b1;
    cycles(122);
    iButtonLevel[0] = 1'b0;
    waitLog(b + 7, 30, "t2_events_timeout");
    if (logId.size() >= b + 7) begin
      check("t2_count", 32'(logId.size()), 32'(b + 7));
      for (int i = 0; i < 7; i++) begin
        check($sformatf("t2_type%0d", i), 32'(logType[b + i]), 32'(expT[i]));
        check($sformatf("t2_id%0d", i),   32'(logId[b + i]),   32'd0);
      end
      check("t2_long_gap", 32'(logCyc[b + 1] - logCyc[b]), 32'd40);
      for (int i = 2; i < 6; i++) begin
        check($sformatf("t2_rep_gap%0d", i), 32'(logCyc[b + i] - logCyc[b + i - 1]), 32'd16);
      end
    end

    // 3. btn1 and btn4 debounce together: round-robin order 1 then 4.
    b = logId.size();
    iButtonLevel = 5'b10010;
    waitLog(b + 2, 20, "t3_press_timeout");
    if (logId.size() >= b + 2) begin
      check("t3_first_id",  32'(logId[b]),     32'd1);
      check("t3_second_id", 32'(logId[b + 1]), 32'd4);
      check("t3_types",     32'(logType[b] + logType[b + 1]), 32'd0);
      check("t3_b2b",       32'(logCyc[b + 1] - logCyc[b]), 32'd1);
    end
    iButtonLevel = 5'b00000;
    waitLog(b + 4, 20, "t3_release_timeout");
    if (logId.size() >= b + 4) begin
      check("t3_rel_first_id",  32'(logId[b + 2]),   32'd1);
      check("t3_rel_second_id", 32'(logId[b + 3]),   32'd4);
      check("t3_rel_type",      32'(logType[b + 3]), 32'd3);
    end

    // 4. Stalled consumer on btn3: output holds PRESS, LONG overwritten by REPEAT.
    b = logId.size();
    iEvtReady = 1'b0;
    iButtonLevel[3] = 1'b1;
    waitValid(20, "t4_valid");
    check("t4_id",   32'(oEvtId),   32'd3);
    check("t4_type", 32'(oEvtType), 32'd0);
    d0 = dropCnt;
    stable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycles(1);
      if (oEvtValid !== 1'b1 || oEvtId !== 3'd3 || oEvtType !== 2'd0) begin
        stable = 1'b0;
      end
    end
    check("t4_stable", 32'(stable), 32'd1);
    check("t4_one_drop", 32'(dropCnt - d0), 32'd1);
    iEvtReady = 1'b1;
    iButtonLevel[3] = 1'b0;
    waitLog(b + 3, 25, "t4_drain_timeout");
    if (logId.size() >= b + 3) begin
      check("t4_out0_type", 32'(logType[b]),     32'd0);
      check("t4_out1_type", 32'(logType[b + 1]), 32'd2);
      check("t4_out2_type", 32'(logType[b + 2]), 32'd3);
      check("t4_out_id",    32'(logId[b + 2]),   32'd3);
      check("t4_b2b",       32'(logCyc[b + 1] - logCyc[b]), 32'd1);
    end
    check("t4_drop_total", 32'(dropCnt - d0), 32'd1);

    // 5. Two-tick glitch low during HELD: no RELEASE, REPEATs continue.
    b = logId.size();
    iButtonLevel[0] = 1'b1;
    waitLog(b + 2, 70, "t5_long_timeout");
    if (logId.size() >= b + 2) begin
      check("t5_long_type", 32'(logType[b + 1]), 32'd1);
    end
    cycles(6);
    iButtonLevel[0] = 1'b0;
    cycles(8);
    iButtonLevel[0] = 1'b1;
    b2 = logId.size();
    waitLog(b2 + 3, 80, "t5_repeat_timeout");
    if (logId.size() >= b2 + 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("t5_rep_type%0d", i), 32'(logType[b2 + i]), 32'd2);
        check($sformatf("t5_rep_id%0d", i),   32'(logId[b2 + i]),   32'd0);
      end
      check("t5_rep_gap", 32'(logCyc[b2 + 2] - logCyc[b2 + 1]), 32'd16);
    end

    // 6. Asynchronous reset mid-HELD, then a fresh debounced press.
    iEvtReady = 1'b0;
    waitValid(40, "t6_valid_before_rst");
    @(posedge iClk);
    #3;
    iRstn = 1'b0;
    #1;
    check("t6_rst_valid", 32'(oEvtValid), 32'd0);
    check("t6_rst_id",    32'(oEvtId),    32'd0);
    check("t6_rst_type",  32'(oEvtType),  32'd0);
    cycles(3);
    iEvtReady = 1'b1;
    b = logId.size();
    iRstn = 1'b1;
    c0 = cyc;
    cycles(12);
    check("t6_quiet_after_rst", 32'(logId.size()), 32'(b));
    cycles(4);
    check("t6_one_press", 32'(logId.size()), 32'(b + 1));
    if (logId.size() >= b + 1) begin
      check("t6_press_type", 32'(logType[b]), 32'd0);
      check("t6_press_id",   32'(logId[b]),   32'd0);
      check("t6_press_lat",  32'(logCyc[b] - c0), 32'd14);
    end

    iButtonLevel = 5'b00000;
    cycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
